// File: rtl/avmm_arbiter.sv
// Round-robin Avalon-MM arbiter: NM masters share one slave port, with write-burst
// locking and an in-order route FIFO that steers read responses back to their issuer.
module avmm_arbiter #(
  parameter int NM        = 2,
  parameter int AW        = 16,
  parameter int DW        = 64,
  parameter int MAX_BURST = 1,
  parameter int MAX_PEND  = 4,
  localparam int BCW = $clog2(MAX_BURST),
  localparam int BW  = BCW + 1,
  localparam int IW  = (NM > 1) ? $clog2(NM) : 1,
  localparam int PW  = $clog2(MAX_PEND)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NM-1:0][AW-1:0]      m_address,
  input  logic [NM-1:0]              m_read,
  input  logic [NM-1:0]              m_write,
  input  logic [NM-1:0][BW-1:0]      m_burstcount,
  input  logic [NM-1:0][DW-1:0]      m_writedata,
  input  logic [NM-1:0][DW/8-1:0]    m_byteenable,
  output logic [NM-1:0]              m_waitrequest,
  output logic [DW-1:0]              m_readdata,
  output logic [NM-1:0]              m_readdatavalid,
  output logic [AW-1:0]              s_address,
  output logic                       s_read,
  output logic                       s_write,
  output logic [BW-1:0]              s_burstcount,
  output logic [DW-1:0]              s_writedata,
  output logic [DW/8-1:0]            s_byteenable,
  input  logic                       s_waitrequest,
  input  logic [DW-1:0]              s_readdata,
  input  logic                       s_readdatavalid,
  output logic                       err_orphan
);

  typedef enum logic {IDLE, WBURST} state_t;

  localparam logic [PW:0] PEND_FULL = MAX_PEND[PW:0];

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   lock_id;
  logic [BW-1:0]   wcnt;

  // Route FIFO: one entry per accepted read command
  logic [IW-1:0]   fifo_id [MAX_PEND];
  logic [BW-1:0]   fifo_bc [MAX_PEND];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic [BW-1:0]   head_cnt;

  logic            full;
  logic            empty;
  logic [IW-1:0]   head_id;
  logic [BW-1:0]   head_bc;
  logic [BW-1:0]   head_eff;
  logic            head_last;
  logic            rsp_beat;
  logic            push;
  logic            pop;

  logic            rr_found;
  logic [IW-1:0]   rr_id;
  logic            wr_found;
  logic [IW-1:0]   wr_id;
  logic [IW:0]     arb_sum;
  logic [IW-1:0]   arb_idx;

  logic            grant_valid;
  logic [IW-1:0]   sel;
  logic            act;
  logic            rd_blocked;
  logic            rd_acc;
  logic            wr_acc;
  logic            burst_start;

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    return (id == IW'(NM - 1)) ? '0 : id + IW'(1);
  endfunction

  assign full  = (count == PEND_FULL);
  assign empty = (count == '0);

  // Circular scan from rr_ptr: first requester of any kind, and first writer
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    wr_found = 1'b0;
    wr_id    = '0;
    arb_sum  = '0;
    arb_idx  = '0;
    for (int k = 0; k < NM; k++) begin
      arb_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (arb_sum >= (IW+1)'(NM))
        arb_sum = arb_sum - (IW+1)'(NM);
      arb_idx = arb_sum[IW-1:0];
      if (!rr_found && (m_read[arb_idx] || m_write[arb_idx])) begin
        rr_found = 1'b1;
        rr_id    = arb_idx;
      end
      if (!wr_found && m_write[arb_idx]) begin
        wr_found = 1'b1;
        wr_id    = arb_idx;
      end
    end
  end

  // A read-only winner facing a full FIFO yields to the next writer in RR order
  always_comb begin
    if (state == WBURST) begin
      grant_valid = 1'b1;
      sel         = lock_id;
    end else if (full && rr_found && !m_write[rr_id] && wr_found) begin
      grant_valid = 1'b1;
      sel         = wr_id;
    end else begin
      grant_valid = rr_found;
      sel         = rr_found ? rr_id : '0;
    end
  end

  assign rd_blocked = (state == IDLE) && full && !m_write[sel];
  assign act        = rst_n && grant_valid;

  always_comb begin
    s_address    = '0;
    s_burstcount = '0;
    s_writedata  = '0;
    s_byteenable = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    if (act) begin
      s_address    = m_address[sel];
      s_burstcount = m_burstcount[sel];
      s_writedata  = m_writedata[sel];
      s_byteenable = m_byteenable[sel];
      s_read       = (state == IDLE) && m_read[sel] && !full;
      s_write      = m_write[sel];
    end
  end

  assign rd_acc      = s_read && !s_waitrequest;
  assign wr_acc      = s_write && !s_waitrequest;
  assign burst_start = (state == IDLE) && wr_acc && (m_burstcount[sel] > BW'(1));

  assign head_id   = fifo_id[rd_ptr];
  assign head_bc   = fifo_bc[rd_ptr];
  assign head_eff  = (head_bc == '0) ? BW'(1) : head_bc;
  assign head_last = (head_cnt == head_eff - BW'(1));
  assign rsp_beat  = s_readdatavalid && !empty;
  assign push      = rd_acc;
  assign pop       = rsp_beat && head_last;

  assign m_readdata = s_readdata;

  for (genvar gi = 0; gi < NM; gi++) begin : g_port
    assign m_waitrequest[gi]   = !(grant_valid && (sel == IW'(gi))) || s_waitrequest || rd_blocked;
    assign m_readdatavalid[gi] = rsp_beat && (head_id == IW'(gi));
  end

  // Grant state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
      wcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (burst_start) begin
            state   <= WBURST;
            lock_id <= sel;
            wcnt    <= m_burstcount[sel] - BW'(1);
          end else if (rd_acc || wr_acc) begin
            rr_ptr <= next_id(sel);
          end
        end
        WBURST: begin
          if (wr_acc) begin
            if (wcnt <= BW'(1)) begin
              state  <= IDLE;
              wcnt   <= '0;
              rr_ptr <= next_id(lock_id);
            end else begin
              wcnt <= wcnt - BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr] <= sel;
      fifo_bc[wr_ptr] <= m_burstcount[sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_cnt   <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (rsp_beat)
        head_cnt <= head_last ? '0 : head_cnt + BW'(1);
      if (s_readdatavalid && empty)
        err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avmm_arbiter.sv
// Bench for avmm_arbiter (NM=2, MAX_BURST=4, MAX_PEND=2): directed scenarios plus a
// read-return scoreboard fed by the issuing masters and drained by m_readdatavalid.
module tb_avmm_arbiter;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int MB = 4;
  localparam int MP = 2;
  localparam int BW = $clog2(MB) + 1;

  logic                    clk;
  logic                    rst_n;
  logic [NM-1:0][AW-1:0]   m_address;
  logic [NM-1:0]           m_read;
  logic [NM-1:0]           m_write;
  logic [NM-1:0][BW-1:0]   m_burstcount;
  logic [NM-1:0][DW-1:0]   m_writedata;
  logic [NM-1:0][DW/8-1:0] m_byteenable;
  logic [NM-1:0]           m_waitrequest;
  logic [DW-1:0]           m_readdata;
  logic [NM-1:0]           m_readdatavalid;
  logic [AW-1:0]           s_address;
  logic                    s_read;
  logic                    s_write;
  logic [BW-1:0]           s_burstcount;
  logic [DW-1:0]           s_writedata;
  logic [DW/8-1:0]         s_byteenable;
  logic                    s_waitrequest;
  logic [DW-1:0]           s_readdata;
  logic                    s_readdatavalid;
  logic                    err_orphan;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [NM-1:0] mask;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
  } rd_t;

  exp_t sb_q[$];
  rd_t  sl_q[$];
  int   sl_beat;

  avmm_arbiter #(
    .NM(NM), .AW(AW), .DW(DW), .MAX_BURST(MB), .MAX_PEND(MP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_burstcount(m_burstcount), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_burstcount(s_burstcount), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a, input int beat);
    return {32'hCAFE_0000, 16'h0000, a} + 64'(beat);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    s_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    m_read          = '0;
    m_write         = '0;
    s_readdatavalid = 1'b0;
    s_waitrequest   = 1'b0;
    sb_q.delete();
    sl_q.delete();
    sl_beat = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Slave model: returns one beat of the oldest read it has seen, or a stray beat
  task automatic drive_ret();
    rd_t h;
    int  eff;
    s_readdatavalid = 1'b1;
    if (sl_q.size() == 0) begin
      s_readdata = 64'hDEAD_BEEF_0000_0000;
      return;
    end
    h   = sl_q[0];
    eff = (h.bc == '0) ? 1 : int'(h.bc);
    s_readdata = rdata(h.addr, sl_beat);
    if (sl_beat == eff - 1) begin
      sl_beat = 0;
      void'(sl_q.pop_front());
    end else begin
      sl_beat++;
    end
  endtask

  task automatic issue_read(input int m, input logic [AW-1:0] a, input int bc);
    logic acc;
    acc = 1'b0;
    m_read[m]       = 1'b1;
    m_write[m]      = 1'b0;
    m_address[m]    = a;
    m_burstcount[m] = BW'(bc);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!m_waitrequest[m]) begin
        acc = 1'b1;
        for (int k = 0; k < ((bc == 0) ? 1 : bc); k++)
          sb_q.push_back('{NM'(1) << m, rdata(a, k)});
        break;
      end
      cyc();
    end
    chk("rd_accept", 64'(acc), 64'd1);
    cyc();
    m_read[m] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && s_read && !s_waitrequest)
      sl_q.push_back('{s_address, s_burstcount});
    if (|m_readdatavalid) begin
      if (sb_q.size() == 0) begin
        chk("rdv_unexpected", 64'(m_readdatavalid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rdv_id", 64'(m_readdatavalid), 64'(e.mask));
        chk("rdv_data", m_readdata, e.data);
        $display("read return to mask %b data %h", m_readdatavalid, m_readdata);
      end
    end
  end

  initial begin
    int beats;
    n_checks        = 0;
    n_errors        = 0;
    sl_beat         = 0;
    rst_n           = 1'b1;
    m_address       = '0;
    m_read          = '0;
    m_write         = '0;
    m_burstcount    = '0;
    m_writedata     = '0;
    m_byteenable    = '1;
    s_waitrequest   = 1'b0;
    s_readdata      = '0;
    s_readdatavalid = 1'b0;
    #2;
    rst_n     = 1'b0;
    m_read[0] = 1'b1;
    m_burstcount[0] = 3'd1;

    // Reset state
    @(negedge clk);
    chk("rst_s_read", 64'(s_read), 64'd0);
    chk("rst_s_write", 64'(s_write), 64'd0);
    chk("rst_rdv", 64'(m_readdatavalid), 64'd0);
    chk("rst_err", 64'(err_orphan), 64'd0);
    m_read = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two simultaneous single reads: m0 then m1, returns in the same order
    m_read          = 2'b11;
    m_address[0]    = 16'h0100;
    m_address[1]    = 16'h0200;
    m_burstcount[0] = 3'd1;
    m_burstcount[1] = 3'd1;
    sb_q.push_back('{2'b01, rdata(16'h0100, 0)});
    sb_q.push_back('{2'b10, rdata(16'h0200, 0)});
    @(negedge clk);
    chk("a_wait_c0", 64'(m_waitrequest), 64'b10);
    chk("a_addr_c0", 64'(s_address), 64'h0100);
    chk("a_sread_c0", 64'(s_read), 64'd1);
    cyc();
    m_read[0] = 1'b0;
    @(negedge clk);
    chk("a_wait_c1", 64'(m_waitrequest), 64'b01);
    chk("a_addr_c1", 64'(s_address), 64'h0200);
    cyc();
    m_read = '0;
    repeat (2) begin
      drive_ret();
      @(negedge clk);
      cyc();
    end
    chk("a_sb_empty", 64'(sb_q.size()), 64'd0);

    // Write burst of 4 from m0 locks out m1 under a toggling s_waitrequest
    do_reset();
    m_write         = 2'b11;
    m_address[0]    = 16'h1000;
    m_burstcount[0] = 3'd4;
    m_address[1]    = 16'h2000;
    m_burstcount[1] = 3'd1;
    m_writedata[1]  = 64'h2222;
    beats = 0;
    for (int t = 0; t < 24 && beats < 4; t++) begin
      s_waitrequest  = (t % 2 == 0);
      m_writedata[0] = 64'h1111_0000 + 64'(beats);
      @(negedge clk);
      if (t == 0)
        chk("b_bcount", 64'(s_burstcount), 64'd4);
      chk("b_m1_stall", 64'(m_waitrequest[1]), 64'd1);
      chk("b_m0_wait", 64'(m_waitrequest[0]), 64'(s_waitrequest));
      chk("b_wdata", s_writedata, 64'h1111_0000 + 64'(beats));
      if (!s_waitrequest) begin
        $display("burst beat %0d accepted", beats);
        beats++;
      end
      cyc();
    end
    s_waitrequest   = 1'b0;
    m_address[0]    = 16'h1100;
    m_burstcount[0] = 3'd1;
    @(negedge clk);
    chk("b_m1_grant", 64'(m_waitrequest), 64'b01);
    chk("b_m1_addr", 64'(s_address), 64'h2000);
    cyc();
    m_write = '0;

    // Full route FIFO blocks reads while a write from the other master passes
    do_reset();
    issue_read(1, 16'h0300, 1);
    issue_read(1, 16'h0310, 1);
    m_read[0]       = 1'b1;
    m_address[0]    = 16'h0320;
    m_burstcount[0] = 3'd1;
    m_write[1]      = 1'b1;
    m_address[1]    = 16'h03F0;
    m_burstcount[1] = 3'd1;
    @(negedge clk);
    chk("c_sread_blk", 64'(s_read), 64'd0);
    chk("c_swrite", 64'(s_write), 64'd1);
    chk("c_wait", 64'(m_waitrequest), 64'b01);
    chk("c_addr", 64'(s_address), 64'h03F0);
    cyc();
    m_write[1] = 1'b0;
    @(negedge clk);
    chk("c_blk_alone", 64'(m_waitrequest[0]), 64'd1);
    chk("c_sread_alone", 64'(s_read), 64'd0);
    cyc();
    drive_ret();
    @(negedge clk);
    chk("c_blk_pop_cycle", 64'(m_waitrequest[0]), 64'd1);
    cyc();
    sb_q.push_back('{2'b01, rdata(16'h0320, 0)});
    @(negedge clk);
    chk("c_unblk", 64'(m_waitrequest[0]), 64'd0);
    chk("c_sread_unblk", 64'(s_read), 64'd1);
    cyc();
    m_read[0] = 1'b0;
    repeat (2) begin
      drive_ret();
      @(negedge clk);
      cyc();
    end
    chk("c_sb_empty", 64'(sb_q.size()), 64'd0);

    // Read burst of 3 from m1 then single read from m0
    do_reset();
    issue_read(1, 16'h0400, 3);
    issue_read(0, 16'h0500, 1);
    repeat (4) begin
      drive_ret();
      @(negedge clk);
      cyc();
    end
    chk("d_sb_empty", 64'(sb_q.size()), 64'd0);

    // Orphan response with nothing pending
    @(negedge clk);
    chk("e_err_pre", 64'(err_orphan), 64'd0);
    cyc();
    drive_ret();
    @(negedge clk);
    chk("e_no_rdv", 64'(m_readdatavalid), 64'd0);
    cyc();
    @(negedge clk);
    chk("e_err_set", 64'(err_orphan), 64'd1);
    repeat (3) cyc();
    @(negedge clk);
    chk("e_err_sticky", 64'(err_orphan), 64'd1);
    do_reset();
    @(negedge clk);
    chk("e_err_clr", 64'(err_orphan), 64'd0);
    cyc();

    // Reset in the middle of a write burst with a read outstanding
    issue_read(0, 16'h0600, 1);
    m_write[0]      = 1'b1;
    m_address[0]    = 16'h0700;
    m_burstcount[0] = 3'd4;
    @(negedge clk);
    chk("f_beat0", 64'(m_waitrequest[0]), 64'd0);
    cyc();
    m_write[1]      = 1'b1;
    m_address[1]    = 16'h0800;
    m_burstcount[1] = 3'd1;
    @(negedge clk);
    chk("f_lock", 64'(m_waitrequest), 64'b10);
    cyc();
    do_reset();
    m_write         = 2'b11;
    m_address[0]    = 16'h0900;
    m_burstcount[0] = 3'd1;
    m_address[1]    = 16'h0A00;
    m_burstcount[1] = 3'd1;
    @(negedge clk);
    chk("f_grant_m0", 64'(m_waitrequest), 64'b10);
    chk("f_addr", 64'(s_address), 64'h0900);
    cyc();
    m_write = '0;
    drive_ret();
    @(negedge clk);
    chk("f_no_rdv", 64'(m_readdatavalid), 64'd0);
    cyc();
    @(negedge clk);
    chk("f_orphan", 64'(err_orphan), 64'd1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
